// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled, midpoint-sampled serial-to-parallel with a
// two-flop input synchronizer, done/frame_err pulses and break handling.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 done,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, rx_s_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   out_q, out_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_d = '0;
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            shift_d[idx_q] = rx_s_q;
            cnt_d          = '0;
            if (idx_q == IdxLast) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_d = '0;
            if (rx_s_q) begin
              out_d   = shift_q;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          // A held-low line must return high before a new start is accepted.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign out       = out_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scoreboard of expected bytes checked on
// each done pulse, plus per-scenario checks of busy, frame_err and out.
module tb_uart_receiver;

  localparam int OS     = 16;
  localparam int EN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       done;
  logic       busy;
  logic       frame_err;

  int   checks    = 0;
  int   passes    = 0;
  int   done_cnt  = 0;
  int   ferr_cnt  = 0;
  bit   busy_seen = 1'b0;
  bit   stall     = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(
    .OVERSAMPLE(OS),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .out      (out),
    .done     (done),
    .busy     (busy),
    .frame_err(frame_err)
  );

  // Sample tick: one en per EN_DIV clocks unless stalled.
  initial begin
    int div;
    div = 0;
    en  = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % EN_DIV;
      en  = (div == 0) && !stall;
    end
  end

  // Output monitor: scoreboard compare on done, pulse-shape checks.
  initial begin
    logic       dp;
    logic       fp;
    logic [7:0] e;
    dp = 1'b0;
    fp = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rx_unexpected_done: out=%h, required no done", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) $display("FAIL rx_byte: out=%h, required %h", out, e);
          else passes++;
        end
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (done === 1'b1 || frame_err === 1'b1) begin
        checks++;
        if ((done && dp) || (frame_err && fp) || (done && frame_err))
          $display("FAIL pulse_shape: done=%b(prev %b) frame_err=%b(prev %b), required single-cycle exclusive pulses",
                   done, dp, frame_err, fp);
        else passes++;
      end
      dp = done;
      fp = frame_err;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic wait_en(input int n);
    int got;
    int guard;
    got   = 0;
    guard = 0;
    while (got < n && guard < n * EN_DIV * 4 + 200) begin
      @(posedge clk);
      guard++;
      if (en) got++;
    end
    if (got < n) begin
      checks++;
      $display("FAIL en_timeout: got %0d en ticks, required %0d", got, n);
    end
  endtask

  task automatic drive_bit(input logic v, input int ticks);
    @(negedge clk);
    in = v;
    wait_en(ticks);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    drive_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], OS);
    drive_bit(stop, OS);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d bytes pending, required 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    in    = 1'b1;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out !== 8'h00) $display("FAIL reset_out: out=%h, required 00", out); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: done=%b, required 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b, required 0", busy); else passes++;
    checks++;
    if (frame_err !== 1'b0) $display("FAIL reset_ferr: frame_err=%b, required 0", frame_err);
    else passes++;
    rst = 1'b0;
    drive_bit(1'b1, 2 * OS);
  endtask

  task automatic test_good_frame();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    send_frame(8'hA5, 1'b1);
    wait_drain();
    checks++; if (busy_seen !== 1'b1) $display("FAIL good_busy_seen: 0, required 1"); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL good_busy_end: busy=%b, required 0", busy); else passes++;
    checks++; if (out !== 8'hA5) $display("FAIL good_out: out=%h, required a5", out); else passes++;
    checks++;
    if (done_cnt - d0 != 1) $display("FAIL good_done_cnt: %0d, required 1", done_cnt - d0);
    else passes++;
    checks++;
    if (ferr_cnt != f0) $display("FAIL good_ferr: %0d, required 0", ferr_cnt - f0);
    else passes++;
    drive_bit(1'b1, OS);
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * OS);
    checks++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen: 0, required 1"); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL glitch_busy: busy=%b, required 0", busy); else passes++;
    checks++; if (out !== 8'hA5) $display("FAIL glitch_out: out=%h, required a5", out); else passes++;
    checks++;
    if (done_cnt != d0 || ferr_cnt != f0)
      $display("FAIL glitch_pulses: done %0d ferr %0d, required 0 0", done_cnt - d0, ferr_cnt - f0);
    else passes++;
  endtask

  task automatic test_frame_err();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 3 * OS);
    checks++; if (busy !== 1'b0) $display("FAIL ferr_break_busy: busy=%b, required 0", busy); else passes++;
    checks++;
    if (ferr_cnt - f0 != 1) $display("FAIL ferr_count: %0d, required 1", ferr_cnt - f0);
    else passes++;
    checks++;
    if (done_cnt != d0) $display("FAIL ferr_done: %0d, required 0", done_cnt - d0);
    else passes++;
    checks++; if (out !== 8'hA5) $display("FAIL ferr_out: out=%h, required a5", out); else passes++;
    drive_bit(1'b1, OS);
    send_frame(8'h5A, 1'b1);
    wait_drain();
    checks++; if (out !== 8'h5A) $display("FAIL ferr_recover_out: out=%h, required 5a", out); else passes++;
    checks++;
    if (ferr_cnt - f0 != 1) $display("FAIL ferr_recover_count: %0d, required 1", ferr_cnt - f0);
    else passes++;
    drive_bit(1'b1, OS);
  endtask

  task automatic test_back_to_back();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain();
    checks++;
    if (done_cnt - d0 != 2) $display("FAIL b2b_done_cnt: %0d, required 2", done_cnt - d0);
    else passes++;
    checks++;
    if (ferr_cnt != f0) $display("FAIL b2b_ferr: %0d, required 0", ferr_cnt - f0);
    else passes++;
    checks++; if (out !== 8'hFF) $display("FAIL b2b_out: out=%h, required ff", out); else passes++;
    drive_bit(1'b1, OS);
  endtask

  task automatic test_reset_mid();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    // 0x81 start, bits 0..2, then half of bit 3
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b0, OS);
    drive_bit(1'b0, OS);
    drive_bit(1'b0, OS / 2);
    @(negedge clk);
    rst = 1'b1;
    in  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: busy=%b, required 0", busy); else passes++;
    checks++; if (out !== 8'h00) $display("FAIL rstmid_out: out=%h, required 00", out); else passes++;
    drive_bit(1'b1, 2 * OS);
    checks++;
    if (done_cnt != d0 || ferr_cnt != f0)
      $display("FAIL rstmid_pulses: done %0d ferr %0d, required 0 0", done_cnt - d0, ferr_cnt - f0);
    else passes++;
    send_frame(8'h81, 1'b1);
    wait_drain();
    checks++; if (out !== 8'h81) $display("FAIL rstmid_next_out: out=%h, required 81", out); else passes++;
    drive_bit(1'b1, OS);
  endtask

  task automatic test_en_stall();
    int d0;
    d0 = done_cnt;
    fork
      send_frame(8'h96, 1'b1);
      begin
        wait_en(5 * OS);
        stall = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done_cnt != d0) $display("FAIL stall_early_done: %0d, required 0", done_cnt - d0);
        else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL stall_busy: busy=%b, required 1", busy); else passes++;
        stall = 1'b0;
      end
    join
    wait_drain();
    checks++;
    if (done_cnt - d0 != 1) $display("FAIL stall_done_cnt: %0d, required 1", done_cnt - d0);
    else passes++;
    checks++; if (out !== 8'h96) $display("FAIL stall_out: out=%h, required 96", out); else passes++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_en_stall();
    drive_bit(1'b1, OS);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
